usb_rx_decode: RTL and testbench
================================

# usb_rx_decode

Front end of the USB RX path: recovers bit timing from the already-synchronized D+/D− lines, NRZI-decodes, removes stuffed bits and detects EOP. Its outputs drive the serial-to-parallel byte receiver directly:
- `serial_out` feeds `serial_in`.
- `shift_en` feeds `cnt_up`.
- `rx_clear` feeds `clear`.

## Interface
Parameters
- CLKS_PER_BIT, 8, clock cycles per USB bit; even, ≥4
- STUFF_LIMIT, 6, consecutive decoded ones after which one stuffed zero follows

Ports
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- d_plus  in  1  D+ line, already synchronized to clk
- d_minus  in  1  D− line, already synchronized to clk
- serial_out  out  1  decoded, unstuffed data bit; valid while shift_en=1
- shift_en  out  1  one-cycle pulse per delivered data bit
- rx_clear  out  1  one-cycle pulse at packet start; clears the downstream byte receiver
- rx_active  out  1  high from packet start until EOP or error recovery completes
- eop  out  1  one-cycle pulse on valid end of packet
- stuff_err  out  1  one-cycle pulse when a seventh consecutive one is decoded

## Operation
- Line states:
  - J = (d_plus=1, d_minus=0).
  - K = (0, 1).
  - SE0 = (0, 0).
  - (1, 1) is treated as SE0.
- Bit timer:
  - Counter is 0..CLKS_PER_BIT−1.
  - Cleared to 0 in any cycle where the line state differs from the previous cycle's state.
  - Otherwise it increments and wraps to 0.
  - A sample strobe fires when counter == CLKS_PER_BIT/2.
- States: IDLE, RECEIVE, EOP_WAIT, ERROR.
- IDLE:
  - On a J→K transition, go to RECEIVE.
  - In the same cycle, pulse rx_clear, set rx_active, set prev_line=J and ones_cnt=0.
- RECEIVE, on each strobe:
  - Sampled SE0 → go to EOP_WAIT.
  - Otherwise bit = (sample == prev_line) ? 1 : 0, then prev_line=sample.
  - If ones_cnt == STUFF_LIMIT and bit=0: drop the bit (no shift_en), ones_cnt=0.
  - If ones_cnt == STUFF_LIMIT and bit=1: pulse stuff_err, go to ERROR.
  - Else: deliver the bit (serial_out=bit, shift_en=1). ones_cnt = bit ? ones_cnt+1 : 0.
- EOP_WAIT, on each strobe:
  - Sampled J → pulse eop, clear rx_active, go to IDLE.
  - SE0 → stay in EOP_WAIT.
  - K → pulse stuff_err, go to ERROR.
- ERROR: rx_active stays high. On a strobe that samples J after at least one SE0 strobe, clear rx_active and go to IDLE. No eop pulse.
- The sync field KJKJKJKK is delivered as data 0,0,0,0,0,0,0,1. Sync stripping is downstream's job.

## Timing
- Reset values: serial_out=1, shift_en=0, rx_clear=0, rx_active=0, eop=0, stuff_err=0, state=IDLE, counter=0, ones_cnt=0.
- Reset applies mid-packet with no eop or error pulse.
- Output latency (all outputs registered):
  - shift_en, serial_out, eop and stuff_err assert in the cycle after the strobe cycle.
  - rx_clear and rx_active assert in the cycle after the J→K transition is seen.
- Steady-state bit spacing:
  - shift_en pulses are exactly CLKS_PER_BIT cycles apart for a continuous run of ones.
  - Spacing stretches or shrinks by the resync on each transition.
- Priority when events coincide on one strobe: SE0 > stuff check > normal delivery.
- rx_clear and the first shift_en are never in the same cycle, because the first strobe is CLKS_PER_BIT/2 cycles after entry.
- ones_cnt saturates at STUFF_LIMIT and never wraps.

## Structure
- Shared package `usb_rx_pkg` holds:
  - line-state enum (J, K, SE0);
  - FSM state enum (IDLE, RECEIVE, EOP_WAIT, ERROR);
  - default STUFF_LIMIT constant.
- Sub-module `usb_rx_bit_timer` holds the line-state register, transition detect, counter and strobe. It is parameterized by CLKS_PER_BIT.
- Top level contains the FSM, NRZI decode, unstuffing and output registers.
- Target size 150–250 lines of RTL.

## Test plan
- Reset mid-packet:
  - Stimulus: rst asserted during RECEIVE.
  - Response: all outputs return to reset values the next cycle; no eop.
- Sync plus byte:
  - Stimulus: idle J, then KJKJKJKK, then NRZI of 0xA5 LSB-first, then SE0 SE0 J, CLKS_PER_BIT=8.
  - Response: one rx_clear; 16 shift_en pulses with serial_out = 0,0,0,0,0,0,0,1,1,0,1,0,0,1,0,1; one eop; rx_active low after it.
- Stuffing:
  - Stimulus: data 0xFF 0x00 with a stuffed zero after six ones.
  - Response: 16 data shift_en pulses plus sync; the stuffed bit is absent; stuff_err never pulses.
- Stuff error:
  - Stimulus: seven consecutive decoded ones.
  - Response: stuff_err pulses once, FSM in ERROR, no shift_en for the seventh one; after SE0 then J, rx_active=0 and no eop.
- Clock drift:
  - Stimulus: bits stretched to 9 cycles, then compressed to 7 cycles.
  - Response: every bit still sampled correctly, because the resync on each transition keeps the strobe mid-bit.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: types and defaults shared across the USB RX front end.
//   line_e        decoded bus line state (J, K, SE0)
//   rx_state_e    receive FSM states
//   decode_line() maps the synchronized D+/D- pair onto a line state
package usb_rx_pkg;

  localparam int STUFF_LIMIT_DEFAULT = 6;

  typedef enum logic [1:0] {
    LINE_J   = 2'd0,
    LINE_K   = 2'd1,
    LINE_SE0 = 2'd2
  } line_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    EOP_WAIT = 2'd2,
    ERROR    = 2'd3
  } rx_state_e;

  // Both lines high is illegal on the bus; it is folded into SE0.
  function automatic line_e decode_line(input logic dp, input logic dm);
    if (dp && !dm)      return LINE_J;
    else if (!dp && dm) return LINE_K;
    else                return LINE_SE0;
  endfunction

endpackage

// File: rtl/usb_rx_decode_if.sv
// usb_rx_decode_if: bus between the USB line, the RX decoder and the
// downstream serial-to-parallel byte receiver.
//   d_plus, d_minus  synchronized line inputs
//   serial_out       decoded, unstuffed data bit (valid with shift_en)
//   shift_en         one pulse per delivered data bit
//   rx_clear         one pulse at packet start
//   rx_active        high while a packet (or error recovery) is in progress
//   eop              one pulse on a valid end of packet
//   stuff_err        one pulse on a bit-stuffing or EOP violation
// master: the decoder. slave: the line driver / byte receiver side.
interface usb_rx_decode_if;
  logic d_plus;
  logic d_minus;
  logic serial_out;
  logic shift_en;
  logic rx_clear;
  logic rx_active;
  logic eop;
  logic stuff_err;

  modport master (
    input  d_plus, d_minus,
    output serial_out, shift_en, rx_clear, rx_active, eop, stuff_err
  );

  modport slave (
    output d_plus, d_minus,
    input  serial_out, shift_en, rx_clear, rx_active, eop, stuff_err
  );
endinterface

// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer: bit-timing recovery.
//   clk, rst          clock, synchronous active-high reset
//   d_plus, d_minus   synchronized line inputs
//   line              registered line state (value of the previous cycle)
//   strobe            high for one cycle at mid-bit (counter == CLKS_PER_BIT/2)
//   jk_edge           combinational: registered line is J, current line is K
// The counter restarts on every line transition, so the strobe tracks the
// transmitter's bit phase even when its clock drifts.
module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  d_plus,
  input  logic  d_minus,
  output line_e line,
  output logic  strobe,
  output logic  jk_edge
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);

  line_e         cur_line;
  logic [CW-1:0] cnt;

  assign cur_line = decode_line(d_plus, d_minus);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      line <= LINE_J;
      cnt  <= '0;
    end else begin
      line <= cur_line;
      if (cur_line != line)     cnt <= '0;
      else if (cnt == CNT_LAST) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
    end
  end

  assign strobe  = (cnt == CNT_MID);
  assign jk_edge = (line == LINE_J) && (cur_line == LINE_K);

endmodule

// File: rtl/usb_rx_decode.sv
// usb_rx_decode: USB RX front end. Recovers bit timing, NRZI-decodes,
// removes stuffed zeros and detects EOP, feeding the byte receiver.
//   clk, rst   clock, synchronous active-high reset
//   bus        usb_rx_decode_if.master (line inputs, decoded outputs)
// All outputs are registered: data/eop/stuff_err appear the cycle after the
// mid-bit strobe, rx_clear/rx_active the cycle after the J->K start edge.
module usb_rx_decode
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = STUFF_LIMIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  usb_rx_decode_if.master bus
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_RECEIVE  = RECEIVE;
  localparam logic [1:0] S_EOP_WAIT = EOP_WAIT;
  localparam logic [1:0] S_ERROR    = ERROR;

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);

  line_e         line;
  logic          strobe;
  logic          jk_edge;

  logic [1:0]    state;
  line_e         prev_line;
  logic [OW-1:0] ones_cnt;
  logic          se0_seen;
  logic          nrzi_bit;

  logic          serial_out_q;
  logic          shift_en_q;
  logic          rx_clear_q;
  logic          rx_active_q;
  logic          eop_q;
  logic          stuff_err_q;

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .d_plus  (bus.d_plus),
    .d_minus (bus.d_minus),
    .line    (line),
    .strobe  (strobe),
    .jk_edge (jk_edge)
  );

  // NRZI: no change in line level is a one, a change is a zero.
  assign nrzi_bit = (line == prev_line);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      prev_line    <= LINE_J;
      ones_cnt     <= '0;
      se0_seen     <= 1'b0;
      serial_out_q <= 1'b1;
      shift_en_q   <= 1'b0;
      rx_clear_q   <= 1'b0;
      rx_active_q  <= 1'b0;
      eop_q        <= 1'b0;
      stuff_err_q  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here; branches below only raise them,
      // which guarantees single-cycle pulses without per-branch clearing.
      shift_en_q  <= 1'b0;
      rx_clear_q  <= 1'b0;
      eop_q       <= 1'b0;
      stuff_err_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (jk_edge) begin
            state       <= S_RECEIVE;
            rx_clear_q  <= 1'b1;
            rx_active_q <= 1'b1;
            prev_line   <= LINE_J;
            ones_cnt    <= '0;
          end
        end

        S_RECEIVE: begin
          if (strobe) begin
            if (line == LINE_SE0) begin
              state <= S_EOP_WAIT;
            end else begin
              prev_line <= line;
              if (ones_cnt == ONES_MAX) begin
                // After a full run of ones the next bit must be a stuffed zero.
                if (nrzi_bit) begin
                  stuff_err_q <= 1'b1;
                  se0_seen    <= 1'b0;
                  state       <= S_ERROR;
                end else begin
                  ones_cnt <= '0;
                end
              end else begin
                serial_out_q <= nrzi_bit;
                shift_en_q   <= 1'b1;
                ones_cnt     <= nrzi_bit ? ones_cnt + 1'b1 : '0;
              end
            end
          end
        end

        S_EOP_WAIT: begin
          if (strobe) begin
            case (line)
              LINE_J: begin
                eop_q       <= 1'b1;
                rx_active_q <= 1'b0;
                state       <= S_IDLE;
              end
              LINE_K: begin
                stuff_err_q <= 1'b1;
                se0_seen    <= 1'b0;
                state       <= S_ERROR;
              end
              default: ;
            endcase
          end
        end

        S_ERROR: begin
          // Recover only on a J that follows at least one SE0 bit time.
          if (strobe) begin
            if (line == LINE_SE0) begin
              se0_seen <= 1'b1;
            end else if (line == LINE_J && se0_seen) begin
              rx_active_q <= 1'b0;
              state       <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.serial_out = serial_out_q;
  assign bus.shift_en   = shift_en_q;
  assign bus.rx_clear   = rx_clear_q;
  assign bus.rx_active  = rx_active_q;
  assign bus.eop        = eop_q;
  assign bus.stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_usb_rx_decode.sv
// tb_usb_rx_decode: directed bench for usb_rx_decode (CLKS_PER_BIT=8,
// STUFF_LIMIT=6). Line levels are driven on the falling edge; a monitor on
// the falling edge records delivered bits and pulse counts for each test.
module tb_usb_rx_decode;
  import usb_rx_pkg::*;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk;
  logic rst;
  usb_rx_decode_if bus ();

  usb_rx_decode #(
    .CLKS_PER_BIT(8),
    .STUFF_LIMIT (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state
  logic bitq[$];
  int   tq[$];
  int   cyc = 0;
  int   clr_cnt = 0;
  int   eop_cnt = 0;
  int   serr_cnt = 0;
  int   overlap = 0;

  logic [1:0] tb_line;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.shift_en) begin
        bitq.push_back(bus.serial_out);
        tq.push_back(cyc);
      end
      if (bus.rx_clear)                 clr_cnt++;
      if (bus.eop)                      eop_cnt++;
      if (bus.stuff_err)                serr_cnt++;
      if (bus.rx_clear && bus.shift_en) overlap++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic line_bit(input logic [1:0] ls, input int cycles);
    bus.d_plus  = ls[1];
    bus.d_minus = ls[0];
    repeat (cycles) @(negedge clk);
  endtask

  task automatic nrzi_bit(input logic b, input int cycles);
    if (!b) tb_line = (tb_line == LJ) ? LK : LJ;
    line_bit(tb_line, cycles);
  endtask

  task automatic send_sync(input int cycles);
    tb_line = LJ;
    for (int i = 0; i < 7; i++) nrzi_bit(1'b0, cycles);
    nrzi_bit(1'b1, cycles);
  endtask

  task automatic send_byte(input logic [7:0] data, input int cycles);
    for (int i = 0; i < 8; i++) nrzi_bit(data[i], cycles);
  endtask

  task automatic send_eop();
    line_bit(LSE0, 8);
    line_bit(LSE0, 8);
    tb_line = LJ;
    line_bit(LJ, 8);
    line_bit(LJ, 16);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tb_line = LJ;
    line_bit(LJ, 4);
    checks++; if (bus.serial_out !== 1'b1) begin errors++; $display("FAIL reset serial_out got %b exp 1", bus.serial_out); end
    checks++; if (bus.shift_en   !== 1'b0) begin errors++; $display("FAIL reset shift_en got %b exp 0", bus.shift_en); end
    checks++; if (bus.rx_clear   !== 1'b0) begin errors++; $display("FAIL reset rx_clear got %b exp 0", bus.rx_clear); end
    checks++; if (bus.rx_active  !== 1'b0) begin errors++; $display("FAIL reset rx_active got %b exp 0", bus.rx_active); end
    checks++; if (bus.eop        !== 1'b0) begin errors++; $display("FAIL reset eop got %b exp 0", bus.eop); end
    checks++; if (bus.stuff_err  !== 1'b0) begin errors++; $display("FAIL reset stuff_err got %b exp 0", bus.stuff_err); end
    rst = 1'b0;
    line_bit(LJ, 16);
  endtask

  task automatic test_reset_mid_packet();
    int e0 = eop_cnt;
    int s0 = serr_cnt;
    tb_line = LJ;
    for (int i = 0; i < 3; i++) nrzi_bit(1'b0, 8);
    checks++; if (bus.rx_active !== 1'b1) begin errors++; $display("FAIL midrst active_before got %b exp 1", bus.rx_active); end
    rst = 1'b1;
    tb_line = LJ;
    bus.d_plus  = 1'b1;
    bus.d_minus = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.serial_out !== 1'b1) begin errors++; $display("FAIL midrst serial_out got %b exp 1", bus.serial_out); end
    checks++; if (bus.shift_en   !== 1'b0) begin errors++; $display("FAIL midrst shift_en got %b exp 0", bus.shift_en); end
    checks++; if (bus.rx_clear   !== 1'b0) begin errors++; $display("FAIL midrst rx_clear got %b exp 0", bus.rx_clear); end
    checks++; if (bus.rx_active  !== 1'b0) begin errors++; $display("FAIL midrst rx_active got %b exp 0", bus.rx_active); end
    checks++; if (bus.eop        !== 1'b0) begin errors++; $display("FAIL midrst eop got %b exp 0", bus.eop); end
    checks++; if (bus.stuff_err  !== 1'b0) begin errors++; $display("FAIL midrst stuff_err got %b exp 0", bus.stuff_err); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL midrst state got %0d exp %0d", dut.state, IDLE); end
    @(negedge clk);
    rst = 1'b0;
    line_bit(LJ, 24);
    checks++; if (bus.rx_active !== 1'b0) begin errors++; $display("FAIL midrst active_after got %b exp 0", bus.rx_active); end
    checks++; if (eop_cnt - e0 !== 0) begin errors++; $display("FAIL midrst eop_pulses got %0d exp 0", eop_cnt - e0); end
    checks++; if (serr_cnt - s0 !== 0) begin errors++; $display("FAIL midrst stuff_err_pulses got %0d exp 0", serr_cnt - s0); end
  endtask

  task automatic test_sync_byte();
    int b0 = bitq.size();
    int c0 = clr_cnt;
    int e0 = eop_cnt;
    int s0 = serr_cnt;
    int o0 = overlap;
    logic [15:0] exp_bits = 16'b0000000110100101;
    send_sync(8);
    send_byte(8'hA5, 8);
    send_eop();
    checks++; if (clr_cnt - c0 !== 1) begin errors++; $display("FAIL sync rx_clear_pulses got %0d exp 1", clr_cnt - c0); end
    checks++; if (bitq.size() - b0 !== 16) begin errors++; $display("FAIL sync bit_count got %0d exp 16", bitq.size() - b0); end
    for (int i = 0; i < 16; i++) begin
      if (b0 + i < bitq.size()) begin
        checks++;
        if (bitq[b0 + i] !== exp_bits[15 - i]) begin
          errors++; $display("FAIL sync bit%0d got %b exp %b", i, bitq[b0 + i], exp_bits[15 - i]);
        end
      end
    end
    checks++; if (eop_cnt - e0 !== 1) begin errors++; $display("FAIL sync eop_pulses got %0d exp 1", eop_cnt - e0); end
    checks++; if (bus.rx_active !== 1'b0) begin errors++; $display("FAIL sync rx_active_after got %b exp 0", bus.rx_active); end
    checks++; if (overlap - o0 !== 0) begin errors++; $display("FAIL sync clear_shift_overlap got %0d exp 0", overlap - o0); end
    checks++; if (serr_cnt - s0 !== 0) begin errors++; $display("FAIL sync stuff_err_pulses got %0d exp 0", serr_cnt - s0); end
  endtask

  task automatic test_stuffing();
    int b0 = bitq.size();
    int e0 = eop_cnt;
    int s0 = serr_cnt;
    logic [23:0] exp_bits = 24'b00000001_11111111_00000000;
    int gap;
    send_sync(8);
    // sync's final one plus five data ones makes six: stuffed zero follows
    for (int i = 0; i < 5; i++) nrzi_bit(1'b1, 8);
    nrzi_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) nrzi_bit(1'b1, 8);
    send_byte(8'h00, 8);
    send_eop();
    checks++; if (bitq.size() - b0 !== 24) begin errors++; $display("FAIL stuff bit_count got %0d exp 24", bitq.size() - b0); end
    for (int i = 0; i < 24; i++) begin
      if (b0 + i < bitq.size()) begin
        checks++;
        if (bitq[b0 + i] !== exp_bits[23 - i]) begin
          errors++; $display("FAIL stuff bit%0d got %b exp %b", i, bitq[b0 + i], exp_bits[23 - i]);
        end
      end
    end
    // ones run: 8-cycle spacing, then a 16-cycle gap across the stuffed bit
    if (bitq.size() - b0 >= 14) begin
      for (int i = 8; i <= 13; i++) begin
        gap = tq[b0 + i] - tq[b0 + i - 1];
        checks++;
        if (gap !== ((i == 13) ? 16 : 8)) begin
          errors++; $display("FAIL stuff spacing%0d got %0d exp %0d", i, gap, (i == 13) ? 16 : 8);
        end
      end
    end
    checks++; if (serr_cnt - s0 !== 0) begin errors++; $display("FAIL stuff stuff_err_pulses got %0d exp 0", serr_cnt - s0); end
    checks++; if (eop_cnt - e0 !== 1) begin errors++; $display("FAIL stuff eop_pulses got %0d exp 1", eop_cnt - e0); end
  endtask

  task automatic test_stuff_error();
    int b0 = bitq.size();
    int e0 = eop_cnt;
    int s0 = serr_cnt;
    send_sync(8);
    for (int i = 0; i < 6; i++) nrzi_bit(1'b1, 8);
    checks++; if (serr_cnt - s0 !== 1) begin errors++; $display("FAIL serr pulses got %0d exp 1", serr_cnt - s0); end
    checks++; if (dut.state !== ERROR) begin errors++; $display("FAIL serr state got %0d exp %0d", dut.state, ERROR); end
    checks++; if (bitq.size() - b0 !== 13) begin errors++; $display("FAIL serr bit_count got %0d exp 13", bitq.size() - b0); end
    checks++; if (bus.rx_active !== 1'b1) begin errors++; $display("FAIL serr rx_active_in_error got %b exp 1", bus.rx_active); end
    send_eop();
    checks++; if (bus.rx_active !== 1'b0) begin errors++; $display("FAIL serr rx_active_after got %b exp 0", bus.rx_active); end
    checks++; if (eop_cnt - e0 !== 0) begin errors++; $display("FAIL serr eop_pulses got %0d exp 0", eop_cnt - e0); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL serr state_after got %0d exp %0d", dut.state, IDLE); end
  endtask

  task automatic test_clock_drift();
    int b0 = bitq.size();
    int e0 = eop_cnt;
    logic [23:0] exp_bits = 24'b00000001_10100101_01011010;
    send_sync(8);
    send_byte(8'hA5, 9);
    send_byte(8'h5A, 7);
    send_eop();
    checks++; if (bitq.size() - b0 !== 24) begin errors++; $display("FAIL drift bit_count got %0d exp 24", bitq.size() - b0); end
    for (int i = 0; i < 24; i++) begin
      if (b0 + i < bitq.size()) begin
        checks++;
        if (bitq[b0 + i] !== exp_bits[23 - i]) begin
          errors++; $display("FAIL drift bit%0d got %b exp %b", i, bitq[b0 + i], exp_bits[23 - i]);
        end
      end
    end
    checks++; if (eop_cnt - e0 !== 1) begin errors++; $display("FAIL drift eop_pulses got %0d exp 1", eop_cnt - e0); end
  endtask

  initial begin
    bus.d_plus  = 1'b1;
    bus.d_minus = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_reset_mid_packet();
    test_sync_byte();
    test_stuffing();
    test_stuff_error();
    test_clock_drift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
